// File: rtl/iir_sched_pkg.sv
// Shared constants and the sum-reduction helper for the multiplexed IIR scheduler.
// Define IIR_SCHED_SAT_EN to clamp results; otherwise results wrap (two's complement).
package iir_sched_pkg;

  localparam int X_SH1    = 1;
  localparam int X_SH2    = 2;
  localparam int Y_SH1    = 1;
  localparam int Y_SH2    = 4;
  localparam int PIPE_LAT = 2;

  // Reduce a sign-extended sum to w+1 signed bits. The result is returned sign-extended to 32 bits.
  function automatic logic signed [31:0] reduce_sum(input logic signed [31:0] s, input int w);
`ifdef IIR_SCHED_SAT_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< w) - 32'sd1;
    lo = -(32'sd1 <<< w);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    logic signed [31:0] t;
    t = s <<< (31 - w);
    return t >>> (31 - w);
`endif
  endfunction

endpackage

// File: rtl/iir_chan_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester after the pointer, wrapping.
// The pointer is returned unchanged when nothing is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] ptr_next_o
);
  localparam int CW = $clog2(N);

  always_comb begin
    logic found;
    int   idx;
    grant_o    = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && elig_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_next_o   = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/iir_chan_sched.sv
// Shares one 2-stage first-order IIR section among NCH channels with round-robin arbitration.
// Define IIR_SCHED_SAT_EN to saturate the output instead of wrapping it.
module iir_chan_sched
  import iir_sched_pkg::*;
#(
  parameter int W   = 14,
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH*(W+1)-1:0]   x_in,
  output logic [NCH-1:0]         req_ready,
  output logic [W:0]             y_out,
  output logic                   y_valid,
  output logic [$clog2(NCH)-1:0] y_chan
);
  localparam int CW = $clog2(NCH);
  localparam int SW = W + 3;

  logic signed [W:0]    xp_q [NCH];
  logic signed [W:0]    yp_q [NCH];
  logic [CW-1:0]        ptr_q;
  logic [CW-1:0]        ptr_d;

  logic                 s1_valid_q;
  logic [CW-1:0]        s1_ch_q;
  logic signed [W:0]    s1_x_q;
  logic signed [SW-1:0] s1_x3_q;
  logic signed [SW-1:0] s1_y9_q;

  logic [W:0]           y_out_q;
  logic                 y_valid_q;
  logic [CW-1:0]        y_chan_q;

  logic [NCH-1:0]       elig;
  logic [NCH-1:0]       grant;
  logic                 accept;
  logic signed [W:0]    x_sel;
  logic signed [W:0]    xp_sel;
  logic signed [W:0]    yp_sel;
  logic signed [SW-1:0] xp_ext;
  logic signed [SW-1:0] yp_ext;
  logic signed [SW-1:0] x3_d;
  logic signed [SW-1:0] y9_d;
  logic signed [SW-1:0] s1_x_ext;
  logic signed [SW-1:0] sum_d;
  logic signed [W:0]    y_d;

  // A channel still in stage 1 must not be re-accepted: its history is not yet written back.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
      assign elig[gi] = req_valid[gi] & ~(s1_valid_q & (s1_ch_q == CW'(gi))) & ~clr & ~reset;
    end
  endgenerate

  rr_arbiter #(.N(NCH)) u_arb (
    .elig_i     (elig),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .ptr_next_o (ptr_d)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  assign x_sel  = x_in[int'(ptr_d)*(W+1) +: (W+1)];
  assign xp_sel = xp_q[ptr_d];
  assign yp_sel = yp_q[ptr_d];
  assign xp_ext = {{2{xp_sel[W]}}, xp_sel};
  assign yp_ext = {{2{yp_sel[W]}}, yp_sel};
  assign x3_d   = (xp_ext >>> X_SH1) + (xp_ext >>> X_SH2);
  assign y9_d   = (yp_ext >>> Y_SH1) + (yp_ext >>> Y_SH2);

  assign s1_x_ext = {{2{s1_x_q[W]}}, s1_x_q};
  assign sum_d    = s1_x_ext + s1_x3_q + s1_y9_q;
  assign y_d      = (W+1)'(reduce_sum(32'(sum_d), W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= CW'(NCH - 1);
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_x_q     <= '0;
      s1_x3_q    <= '0;
      s1_y9_q    <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      y_chan_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        xp_q[i] <= '0;
        yp_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_ch_q <= ptr_d;
        s1_x_q  <= x_sel;
        s1_x3_q <= x3_d;
        s1_y9_q <= y9_d;
      end
      // A flush kills the stage-1 operation; the already-registered result stays visible.
      y_valid_q <= s1_valid_q & ~clr;
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          xp_q[i] <= '0;
          yp_q[i] <= '0;
        end
      end else if (s1_valid_q) begin
        y_out_q        <= y_d;
        y_chan_q       <= s1_ch_q;
        xp_q[s1_ch_q]  <= s1_x_q;
        yp_q[s1_ch_q]  <= y_d;
      end
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign y_chan  = y_chan_q;

endmodule

// File: tb/tb_iir_chan_sched.sv
// Self-checking bench for iir_chan_sched: directed vector table, corner sequences and a
// randomized run against a queue-based reference model of the recurrence and scheduling rules.
`timescale 1ns/1ps
module tb_iir_chan_sched;
  import iir_sched_pkg::*;

  localparam int W   = 14;
  localparam int NCH = 4;
  localparam int SWD = W + 1;
`ifdef IIR_SCHED_SAT_EN
  localparam int OVF_Y = 16383;
`else
  localparam int OVF_Y = 5115;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clr;
  logic [NCH-1:0]       req_valid;
  logic [NCH*SWD-1:0]   x_in;
  logic [NCH-1:0]       req_ready;
  logic [W:0]           y_out;
  logic                 y_valid;
  logic [1:0]           y_chan;

  always #5 clk = ~clk;

  iir_chan_sched #(.W(W), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .req_valid (req_valid),
    .x_in      (x_in),
    .req_ready (req_ready),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .y_chan    (y_chan)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int ch; int y; } ent_t;
  ent_t pend[$];
  int   m_xp [NCH];
  int   m_yp [NCH];
  int   m_ptr, m_grant, ecount;
  logic m_yv;
  int   m_y, m_ch;

  logic [NCH-1:0] a_ready;
  logic           a_yv;
  int             a_y, a_ch;

  typedef struct {
    logic [NCH-1:0] vld; int x; logic clr;
    logic [NCH-1:0] rdy; logic yv; int y; int ch;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fl(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int red(input int s);
`ifdef IIR_SCHED_SAT_EN
    if (s > (2**W) - 1) return (2**W) - 1;
    if (s < -(2**W)) return -(2**W);
    return s;
`else
    int r;
    r = (s + 2**W) % (2**(W+1));
    if (r < 0) r = r + 2**(W+1);
    return r - 2**W;
`endif
  endfunction

  function automatic logic [NCH*SWD-1:0] rep(input int x);
    logic [NCH*SWD-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*SWD +: SWD] = SWD'(x);
    return r;
  endfunction

  function automatic int sample(input int c);
    return int'($signed(x_in[c*SWD +: SWD]));
  endfunction

  task automatic m_reset();
    pend.delete();
    for (int c = 0; c < NCH; c++) begin m_xp[c] = 0; m_yp[c] = 0; end
    m_ptr = NCH - 1; m_grant = -1; m_yv = 1'b0; m_y = 0; m_ch = 0;
  endtask

  function automatic bit m_busy(input int c);
    foreach (pend[i]) if (pend[i].due == ecount + PIPE_LAT - 1 && pend[i].ch == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pick();
    if (reset || clr) return -1;
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (m_ptr + i) % NCH;
      if (req_valid[c] && !m_busy(c)) return c;
    end
    return -1;
  endfunction

  // Model an active clock edge using the inputs held across it.
  task automatic m_edge();
    ecount++;
    if (reset) begin
      m_reset();
      return;
    end
    if (clr) begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due == ecount) pend.delete(i);
      for (int c = 0; c < NCH; c++) begin m_xp[c] = 0; m_yp[c] = 0; end
    end else if (m_grant >= 0) begin
      int xv, y;
      xv = sample(m_grant);
      y  = red(xv + fl(m_xp[m_grant], 2) + fl(m_xp[m_grant], 4)
                  + fl(m_yp[m_grant], 2) + fl(m_yp[m_grant], 16));
      pend.push_back('{due: ecount + PIPE_LAT - 1, ch: m_grant, y: y});
      m_xp[m_grant] = xv;
      m_yp[m_grant] = y;
      m_ptr = m_grant;
    end
    m_yv = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == ecount) begin
        m_yv = 1'b1; m_y = pend[i].y; m_ch = pend[i].ch;
        pend.delete(i);
      end
    end
  endtask

  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*SWD-1:0] x, input logic c);
    req_valid = v; x_in = x; clr = c;
    @(negedge clk);
    m_grant = m_pick();
    a_ready = req_ready; a_yv = y_valid; a_y = int'($signed(y_out)); a_ch = int'(y_chan);
    chk("req_ready", int'(a_ready), (m_grant >= 0) ? (1 << m_grant) : 0);
    chk("y_valid", int'(a_yv), int'(m_yv));
    if (m_yv) begin
      chk("y_out", a_y, m_y);
      chk("y_chan", a_ch, m_ch);
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  initial begin
    logic [NCH*SWD-1:0] xr;
    tbl[0]  = '{4'b0001, 1000,  1'b0, 4'b0001, 1'b0, 0,     0};
    tbl[1]  = '{4'b0000, 0,     1'b0, 4'b0000, 1'b0, 0,     0};
    tbl[2]  = '{4'b0001, 0,     1'b0, 4'b0001, 1'b1, 1000,  0};
    tbl[3]  = '{4'b0000, 0,     1'b0, 4'b0000, 1'b0, 0,     0};
    tbl[4]  = '{4'b0001, 0,     1'b0, 4'b0001, 1'b1, 1312,  0};
    tbl[5]  = '{4'b0010, 0,     1'b0, 4'b0010, 1'b0, 0,     0};
    tbl[6]  = '{4'b0000, 0,     1'b0, 4'b0000, 1'b1, 738,   0};
    tbl[7]  = '{4'b0000, 0,     1'b0, 4'b0000, 1'b1, 0,     1};
    tbl[8]  = '{4'b0001, 0,     1'b1, 4'b0000, 1'b0, 0,     0};
    tbl[9]  = '{4'b0001, 16383, 1'b0, 4'b0001, 1'b0, 0,     0};
    tbl[10] = '{4'b0000, 0,     1'b0, 4'b0000, 1'b0, 0,     0};
    tbl[11] = '{4'b0001, 16383, 1'b0, 4'b0001, 1'b1, 16383, 0};
    tbl[12] = '{4'b0000, 0,     1'b0, 4'b0000, 1'b0, 0,     0};
    tbl[13] = '{4'b0000, 0,     1'b0, 4'b0000, 1'b1, OVF_Y, 0};

    reset = 1'b1; clr = 1'b0; req_valid = '0; x_in = '0; ecount = 0;
    m_reset();
    repeat (2) begin @(posedge clk); m_edge(); end
    #1 req_valid = '1; x_in = rep(1234);
    #1;
    chk("reset req_ready", int'(req_ready), 0);
    chk("reset y_valid", int'(y_valid), 0);
    chk("reset y_out", int'(y_out), 0);
    chk("reset y_chan", int'(y_chan), 0);
    reset = 1'b0; req_valid = '0;

    // Impulse, cross-channel isolation, flush and overflow vectors.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].vld, rep(tbl[i].x), tbl[i].clr);
      chk($sformatf("tbl%0d ready", i), int'(a_ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d y_valid", i), int'(a_yv), int'(tbl[i].yv));
      if (tbl[i].yv) begin
        chk($sformatf("tbl%0d y_out", i), a_y, tbl[i].y);
        chk($sformatf("tbl%0d y_chan", i), a_ch, tbl[i].ch);
      end
    end

    // Full load: a grant every cycle, rotating from channel 1.
    for (int i = 0; i < 12; i++) begin
      cycle('1, rep(2000), 1'b0);
      chk($sformatf("full%0d grant", i), int'(a_ready), 1 << ((1 + i) % NCH));
    end

    // Hazard: a lone channel is granted every other cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0100, rep(300 + i), 1'b0);
      chk($sformatf("hazard%0d ready2", i), int'(a_ready[2]), (i % 2 == 0) ? 1 : 0);
    end

    // Flush the cycle after accepting channel 1.
    cycle(4'b0010, rep(500), 1'b0);
    chk("clr accept ch1", int'(a_ready), 2);
    cycle(4'b0000, rep(0), 1'b1);
    cycle(4'b0000, rep(0), 1'b0);
    chk("clr killed y_valid", int'(a_yv), 0);
    cycle(4'b0010, rep(1000), 1'b0);
    chk("post-clr accept ch1", int'(a_ready), 2);
    cycle(4'b0000, rep(0), 1'b0);
    cycle(4'b0000, rep(0), 1'b0);
    chk("post-clr y_valid", int'(a_yv), 1);
    chk("post-clr y_out", a_y, 1000);
    chk("post-clr y_chan", a_ch, 1);

    // Asynchronous reset in the middle of a busy cycle.
    repeat (3) cycle('1, rep(777), 1'b0);
    #1 reset = 1'b1;
    m_reset();
    #1;
    chk("arst y_valid", int'(y_valid), 0);
    chk("arst y_out", int'(y_out), 0);
    chk("arst y_chan", int'(y_chan), 0);
    chk("arst req_ready", int'(req_ready), 0);
    @(posedge clk);
    m_edge();
    #1 reset = 1'b0;
    cycle('1, rep(777), 1'b0);
    chk("arst first grant", int'(a_ready), 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) xr[c*SWD +: SWD] = SWD'($urandom_range(0, 32767));
      cycle(NCH'($urandom_range(0, 15)), xr, ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_chan_sched.md
# iir_chan_sched

Time-multiplexed scheduler that shares one pipelined first-order IIR section among NCH input channels. It arbitrates per-channel valid/ready requests round-robin and keeps each channel's filter history in register banks. Each accepted sample is issued into a 2-stage shift-add datapath, and the result is written back. Sits between the per-channel sample sources and the downstream result sink; replaces NCH separate filter instances.

## Interface
- W, 14: sample bit width minus 1 (samples are W+1 bits, signed)
- NCH, 4: number of channels, 2..16
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous flush of all channel history and in-flight work
- req_valid  in  NCH  per-channel sample valid
- x_in  in  NCH*(W+1)  packed samples; channel c occupies bits [c*(W+1) +: W+1]
- req_ready  out  NCH  one-hot-or-zero grant; a sample transfers when req_valid[c] & req_ready[c]
- y_out  out  W+1  filtered result, signed
- y_valid  out  1  y_out/y_chan valid this cycle
- y_chan  out  clog2(NCH)  channel index of y_out

## Operation
- Recurrence per channel c: y[n] = x[n] + (3/4)·x[n-1] + (9/16)·y[n-1].
- Coefficients are realised as arithmetic shifts only: (xp>>>1)+(xp>>>2) and (yp>>>1)+(yp>>>4), truncating toward −∞.
- Per-channel history registers xp[c], yp[c], each W+1 bits, reset to 0.
- Arbitration: round-robin pointer holds the last granted channel. Grant goes to the first eligible channel after the pointer, wrapping. The pointer updates only on an accepted transfer.
- Eligible: req_valid[c]=1, c not currently in stage 1, and clr=0. req_ready is combinational from req_valid and is never asserted for a non-eligible channel.
- Stage 1 (accept edge): register x, channel index, x3 from xp[c], and y9 from yp[c].
- Stage 2: y = x + x3 + y9, summed at W+3 bits then reduced to W+1 (see Configuration). At this edge y_out, y_chan and y_valid are registered, and xp[c]<=x, yp[c]<=y.
- Hazard rule: a channel in stage 1 is ineligible, so each channel is accepted at most every other cycle. Different channels may be accepted back-to-back.
- clr: all xp/yp are zeroed and the stage-1 valid bit is cleared, so that operation produces no y_valid. A stage-2 result already registered is still presented this cycle. No accept occurs in a clr cycle. The pointer is unchanged.

## Timing
- Latency: accept at edge E0 gives y_valid high after E1, i.e. 2 edges.
- Throughput: one sample per cycle across channels; one per 2 cycles per channel.
- y_valid is a single-cycle pulse per result. The sink has no backpressure and must accept every result.
- Reset values: y_out=0, y_valid=0, y_chan=0, req_ready=0 while reset is asserted, all history=0, pipeline empty, pointer=NCH-1 so channel 0 has first priority.
- Reset asserted mid-operation discards in-flight samples immediately (asynchronous).

## Configuration
- IIR_SCHED_SAT_EN defined: the W+3-bit sum is clamped to [−2^W, 2^W−1] before it is output and written back.
- Not defined: the sum wraps, keeping the low W+1 bits, two's complement.

## Structure
- Package iir_sched_pkg holds:
  - shift constants X_SH1=1, X_SH2=2, Y_SH1=1, Y_SH2=4
  - PIPE_LAT=2
  - a saturate/wrap function on the W+3-bit sum
- Sub-module rr_arbiter (parameter N) takes the eligible vector and the pointer, and returns a one-hot grant and the next pointer.

## Test plan
- Impulse on ch0: x=1000, then 0, 0. Required y_out=1000, 1312, 738 with y_chan=0; history of ch1..3 stays 0.
- Full load: all four req_valid held high with constant samples. Grants cycle 0,1,2,3,0,… every cycle; y_chan follows 2 cycles later; no cycle has an idle grant.
- Hazard: only ch2 valid, held high. req_ready[2] alternates 1,0,1,0; y_valid pulses every other cycle.
- Overflow: ch0 x=16383 twice. Second result is 5115 without IIR_SCHED_SAT_EN and 16383 with it.
- clr mid-stream: assert clr the cycle after accepting ch1. No y_valid for that ch1 sample. The next ch1 x=1000 yields y_out=1000.
- Async reset mid-run: all outputs are 0 before the next edge. The first grant after release goes to ch0.
